// File: rtl/pixel_writer_pkg.sv
// Shared definitions for pixel_writer: command codes, pixel_cmd field positions,
// FSM states and pixel-width helpers.
package pixel_writer_pkg;

    typedef enum logic [3:0] {
        CMD_PXWRI         = 4'd1,
        CMD_PXWRI_M       = 4'd2,
        CMD_PXPASTE       = 4'd3,
        CMD_PXPASTE_M     = 4'd4,
        CMD_PXCOPY        = 4'd6,
        CMD_SETARGB       = 4'd7,
        CMD_RST_PXWRI_M   = 4'd10,
        CMD_RST_PXPASTE_M = 4'd11
    } cmd_e;

    localparam int CMD_HI     = 39;
    localparam int CMD_LO     = 36;
    localparam int COLOUR_HI  = 35;
    localparam int COLOUR_LO  = 28;
    localparam int WIDTH_HI   = 27;
    localparam int WIDTH_LO   = 24;
    localparam int TARGET_HI  = 23;
    localparam int TARGET_LO  = 20;
    localparam int PAYLOAD_HI = 31;
    localparam int PAYLOAD_LO = 0;
    localparam int MASK_HI    = 31;
    localparam int MASK_LO    = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR
    } state_e;

    function automatic logic width_legal(input logic [3:0] width);
        return (width == 4'd0) || (width == 4'd1) || (width == 4'd3) ||
               (width == 4'd7) || (width == 4'd15);
    endfunction

    // Pixels per word minus one; only meaningful for legal widths.
    function automatic logic [3:0] lane_mask(input logic [3:0] width);
        logic [3:0] m;
        case (width)
            4'd0:    m = 4'd15;
            4'd1:    m = 4'd7;
            4'd3:    m = 4'd3;
            4'd7:    m = 4'd1;
            default: m = 4'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pixel_lane_mux.sv
// Combinational extract/insert of one MSB-first pixel lane in a 16-bit word.
module pixel_lane_mux (
    input  logic [15:0] word,
    input  logic [3:0]  width,
    input  logic [3:0]  lane,
    input  logic [15:0] pixel,
    output logic [15:0] extracted,
    output logic [15:0] merged
);

    logic [4:0]  bpp;
    logic [4:0]  shift;
    logic [15:0] low_mask;
    logic [15:0] field_mask;

    always_comb begin
        bpp        = {1'b0, width} + 5'd1;
        // Lane 0 sits at the top of the word, so the LSB offset counts down.
        shift      = 5'd16 - 5'(bpp * {1'b0, lane}) - bpp;
        low_mask   = 16'hFFFF >> (5'd16 - bpp);
        field_mask = low_mask << shift;
        extracted  = (word >> shift) & low_mask;
        merged     = (word & ~field_mask) | ((pixel & low_mask) << shift);
    end

endmodule

// File: rtl/pixel_writer.sv
// Pixel command executor: RMW / full-word write / read against 16-bit graphics memory.
// Optional build macro PIXEL_WRITER_COLLISION_EN enables the read-collision counter.
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_cmd_rdy,
    input  logic [39:0]       pixel_cmd,
    output logic              draw_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic [31:0]       argb,
    output logic [CNT_W-1:0]  collision_cnt
);

    state_e state, next_state;

    logic [3:0]  f_cmd, f_width, f_target;
    logic [7:0]  f_colour;
    logic        accept, is_wri, is_paste, is_copy, skip, start_mem, full_word;

    logic              op_copy_r, op_wri_r;
    logic [7:0]        colour_r;
    logic [3:0]        width_r, lane_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       word_r, copy_buf;
    logic [7:0]        wri_mask, paste_mask;
    logic [15:0]       lane_pixel, extracted, merged;
    logic              rd_done;

    assign f_cmd    = pixel_cmd[CMD_HI:CMD_LO];
    assign f_colour = pixel_cmd[COLOUR_HI:COLOUR_LO];
    assign f_width  = pixel_cmd[WIDTH_HI:WIDTH_LO];
    assign f_target = pixel_cmd[TARGET_HI:TARGET_LO];

    assign accept   = pixel_cmd_rdy && (state == ST_IDLE);
    assign is_wri   = (f_cmd == CMD_PXWRI)   || (f_cmd == CMD_PXWRI_M);
    assign is_paste = (f_cmd == CMD_PXPASTE) || (f_cmd == CMD_PXPASTE_M);
    assign is_copy  = (f_cmd == CMD_PXCOPY);
    assign skip     = ((f_cmd == CMD_PXWRI_M)   && (f_colour == wri_mask)) ||
                      ((f_cmd == CMD_PXPASTE_M) && (copy_buf == {8'h00, paste_mask}));
    assign start_mem = accept && width_legal(f_width) &&
                       (is_copy || ((is_wri || is_paste) && !skip));
    assign full_word = (f_width == 4'd15) && !is_copy;
    assign rd_done   = (state == ST_RD_WAIT) && mem_rvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (start_mem) next_state = full_word ? ST_WR : ST_RD_REQ;
            ST_RD_REQ:  if (mem_ack) next_state = ST_RD_WAIT;
            ST_RD_WAIT: if (mem_rvalid) next_state = op_copy_r ? ST_IDLE : ST_WR;
            ST_WR:      if (mem_ack) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    assign draw_busy = (state != ST_IDLE);
    assign mem_req   = (state == ST_RD_REQ) || (state == ST_WR);
    assign mem_we    = (state == ST_WR);
    assign mem_addr  = addr_r & ~ADDR_W'(1);
    assign mem_wdata = word_r;

    assign lane_pixel = op_wri_r ? {8'h00, colour_r} : copy_buf;

    pixel_lane_mux u_lane_mux (
        .word      (mem_rdata),
        .width     (width_r),
        .lane      (lane_r),
        .pixel     (lane_pixel),
        .extracted (extracted),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_copy_r  <= 1'b0;
            op_wri_r   <= 1'b0;
            colour_r   <= '0;
            width_r    <= '0;
            lane_r     <= '0;
            addr_r     <= '0;
            word_r     <= '0;
            copy_buf   <= '0;
            wri_mask   <= '0;
            paste_mask <= '0;
            argb       <= '0;
        end else begin
            if (accept) begin
                if (f_cmd == CMD_SETARGB)       argb       <= pixel_cmd[PAYLOAD_HI:PAYLOAD_LO];
                if (f_cmd == CMD_RST_PXWRI_M)   wri_mask   <= pixel_cmd[MASK_HI:MASK_LO];
                if (f_cmd == CMD_RST_PXPASTE_M) paste_mask <= pixel_cmd[MASK_HI:MASK_LO];
            end
            if (start_mem) begin
                op_copy_r <= is_copy;
                op_wri_r  <= is_wri;
                colour_r  <= f_colour;
                width_r   <= f_width;
                lane_r    <= f_target & lane_mask(f_width);
                addr_r    <= pixel_cmd[ADDR_W-1:0];
                // 16bpp writes skip the read, so the word is known up front.
                if (full_word) word_r <= is_wri ? {8'h00, f_colour} : copy_buf;
            end
            if (rd_done) begin
                if (op_copy_r) copy_buf <= extracted;
                else           word_r   <= merged;
            end
        end
    end

`ifdef PIXEL_WRITER_COLLISION_EN
    logic [CNT_W-1:0] cnt_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (accept && ((f_cmd == CMD_RST_PXWRI_M) || (f_cmd == CMD_RST_PXPASTE_M))) begin
            cnt_r <= '0;
        end else if (rd_done && op_copy_r && (extracted != {8'h00, colour_r}) && (cnt_r != '1)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign collision_cnt = cnt_r;
`else
    assign collision_cnt = '0;
`endif

endmodule
